// File: rtl/ahb3lite_master_port.sv
// Single-transfer AHB3-Lite initiator: valid/ready commands in, NONSEQ/SINGLE
// transfers out, one in-order response per command, with error-cancel replay.
module ahb3lite_master_port #(
  parameter int unsigned HADDR_SIZE = 8,
  parameter int unsigned HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [HADDR_SIZE-1:0] cmd_addr,
  input  logic [2:0]            cmd_size,
  input  logic [HDATA_SIZE-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic                  rsp_error,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HREADY,
  input  logic                  HREADYOUT,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HRESP
);

  localparam int unsigned MAX_SIZE    = $clog2(HDATA_SIZE / 8);
  localparam logic [1:0]  HTRANS_IDLE = 2'b00;
  localparam logic [1:0]  HTRANS_NSEQ = 2'b10;

  // Address-phase, data-phase and replay registers
  logic                  a_valid_q, a_valid_d;
  logic [HADDR_SIZE-1:0] a_addr_q, a_addr_d;
  logic                  a_write_q, a_write_d;
  logic [2:0]            a_size_q, a_size_d;
  logic [HDATA_SIZE-1:0] a_wdata_q, a_wdata_d;
  logic                  d_valid_q, d_valid_d;
  logic                  d_write_q, d_write_d;
  logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
  logic                  r_valid_q, r_valid_d;
  logic [HADDR_SIZE-1:0] r_addr_q, r_addr_d;
  logic                  r_write_q, r_write_d;
  logic [2:0]            r_size_q, r_size_d;
  logic [HDATA_SIZE-1:0] r_wdata_q, r_wdata_d;
  logic                  err1_q, err1_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic                  rsp_error_q, rsp_error_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  err_first_c;
  logic                  cmd_fire_c;
  logic [2:0]            cmd_size_sat_c;
  logic [HADDR_SIZE-1:0] cmd_addr_al_c;

  // First ERROR cycle: no new command may enter while the cancel is decided
  assign err_first_c    = d_valid_q && HRESP && !HREADYOUT;
  assign cmd_ready      = HRESETn && !r_valid_q && !err1_q && !err_first_c &&
                          (!a_valid_q || HREADYOUT);
  assign cmd_fire_c     = cmd_valid && cmd_ready;
  assign cmd_size_sat_c = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;
  assign cmd_addr_al_c  = (cmd_addr >> cmd_size_sat_c) << cmd_size_sat_c;

  assign HSEL      = a_valid_q;
  assign HTRANS    = a_valid_q ? HTRANS_NSEQ : HTRANS_IDLE;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HWDATA    = hwdata_q;
  assign HREADY    = HREADYOUT;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_error = rsp_error_q;
  assign rsp_rdata = rsp_rdata_q;

  // Next-state: pipeline advance, wait-state hold, error cancel and replay
  always_comb begin
    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    hwdata_d    = hwdata_q;
    r_valid_d   = r_valid_q;
    r_addr_d    = r_addr_q;
    r_write_d   = r_write_q;
    r_size_d    = r_size_q;
    r_wdata_d   = r_wdata_q;
    err1_d      = err1_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;

    if (HREADYOUT) begin
      err1_d    = 1'b0;
      d_valid_d = a_valid_q;
      if (a_valid_q) begin
        d_write_d = a_write_q;
        hwdata_d  = a_wdata_q;
      end
      if (d_valid_q) begin
        rsp_valid_d = 1'b1;
        rsp_write_d = d_write_q;
        rsp_error_d = HRESP;
        rsp_rdata_d = (!d_write_q && !HRESP) ? HRDATA : '0;
      end
    end else if (err_first_c) begin
      err1_d = 1'b1;
    end

    if (cmd_fire_c) begin
      a_valid_d = 1'b1;
      a_addr_d  = cmd_addr_al_c;
      a_write_d = cmd_write;
      a_size_d  = cmd_size_sat_c;
      a_wdata_d = cmd_wdata;
    end else if (HREADYOUT) begin
      if (r_valid_q) begin
        a_valid_d = 1'b1;
        a_addr_d  = r_addr_q;
        a_write_d = r_write_q;
        a_size_d  = r_size_q;
        a_wdata_d = r_wdata_q;
        r_valid_d = 1'b0;
      end else begin
        a_valid_d = 1'b0;
      end
    end else if (err_first_c && a_valid_q) begin
      r_valid_d = 1'b1;
      r_addr_d  = a_addr_q;
      r_write_d = a_write_q;
      r_size_d  = a_size_q;
      r_wdata_d = a_wdata_q;
      a_valid_d = 1'b0;
    end
  end

  // State registers, all cleared by reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= '0;
      a_write_q   <= 1'b0;
      a_size_q    <= '0;
      a_wdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      hwdata_q    <= '0;
      r_valid_q   <= 1'b0;
      r_addr_q    <= '0;
      r_write_q   <= 1'b0;
      r_size_q    <= '0;
      r_wdata_q   <= '0;
      err1_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      hwdata_q    <= hwdata_d;
      r_valid_q   <= r_valid_d;
      r_addr_q    <= r_addr_d;
      r_write_q   <= r_write_d;
      r_size_q    <= r_size_d;
      r_wdata_q   <= r_wdata_d;
      err1_q      <= err1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

endmodule

// File: tb/tb_ahb3lite_master_port.sv
// Directed bench for ahb3lite_master_port with a small word-memory slave
// that can insert read wait states or a two-cycle ERROR on one address.
module tb_ahb3lite_master_port;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [2:0]  cmd_size = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [7:0]  HADDR;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  ahb3lite_master_port #(.HADDR_SIZE(8), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_error(rsp_error),
    .rsp_rdata(rsp_rdata), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Slave model
  logic [31:0] mem [0:63];
  logic        dp_valid, dp_write;
  logic [7:0]  dp_addr;
  int          waits_left;
  logic [1:0]  err_st;
  logic        wait_en = 1'b0, err_en = 1'b0;
  logic [7:0]  wait_addr = '0, err_addr = '0;
  int          wait_n = 0;

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    if (dp_valid) begin
      if (err_st == 2'd1) begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end else if (err_st == 2'd2) begin
        HRESP = 1'b1;
      end else if (waits_left > 0) begin
        HREADYOUT = 1'b0;
      end else if (!dp_write) begin
        HRDATA = mem[dp_addr[7:2]];
      end
    end
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      dp_addr    <= '0;
      waits_left <= 0;
      err_st     <= 2'd0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else if (HREADY) begin
      if (dp_valid && dp_write && !HRESP) mem[dp_addr[7:2]] <= HWDATA;
      dp_valid   <= HSEL && HTRANS[1];
      dp_addr    <= HADDR;
      dp_write   <= HWRITE;
      waits_left <= (wait_en && !HWRITE && HADDR == wait_addr) ? wait_n : 0;
      err_st     <= (err_en && HSEL && HTRANS[1] && HADDR == err_addr) ? 2'd1 : 2'd0;
    end else begin
      if (err_st == 2'd1) err_st <= 2'd2;
      else if (waits_left > 0) waits_left <= waits_left - 1;
    end
  end

  // Response log
  int          rsp_cyc_q[$];
  logic        rsp_w_q[$];
  logic        rsp_e_q[$];
  logic [31:0] rsp_d_q[$];

  always @(negedge HCLK) begin
    if (HRESETn && rsp_valid) begin
      rsp_cyc_q.push_back(cyc);
      rsp_w_q.push_back(rsp_write);
      rsp_e_q.push_back(rsp_error);
      rsp_d_q.push_back(rsp_rdata);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Offer a command; acc is the cycle in which cmd_valid&&cmd_ready held
  task automatic issue(input logic w, input logic [7:0] addr, input logic [2:0] size,
                       input logic [31:0] wd, output int acc);
    int n;
    acc = -1;
    n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = addr;
    cmd_size  = size;
    cmd_wdata = wd;
    while (acc < 0 && n < 30) begin
      @(negedge HCLK);
      if (cmd_ready) acc = cyc;
      @(posedge HCLK);
      #1;
      n++;
    end
    checks++;
    if (acc < 0) begin
      fails++;
      $display("FAIL accept_timeout: addr %h not accepted within %0d cycles", addr, n);
    end
  endtask

  task automatic wait_rsp(input int want);
    int n;
    n = 0;
    while (rsp_cyc_q.size() < want && n < 40) begin
      tick(1);
      n++;
    end
    checks++;
    if (rsp_cyc_q.size() < want) begin
      fails++;
      $display("FAIL rsp_timeout: got %0d responses, expected %0d", rsp_cyc_q.size(), want);
    end
  endtask

  task automatic test_reset;
    #2;
    checks++; if (HTRANS !== 2'b00) begin fails++; $display("FAIL rst_htrans: got %b exp 00", HTRANS); end
    checks++; if (HSEL !== 1'b0) begin fails++; $display("FAIL rst_hsel: got %b exp 0", HSEL); end
    checks++; if (HADDR !== 8'h00 || HWRITE !== 1'b0 || HSIZE !== 3'b000) begin
      fails++; $display("FAIL rst_addr: got %h/%b/%b exp 00/0/000", HADDR, HWRITE, HSIZE); end
    checks++; if (HWDATA !== 32'h0) begin fails++; $display("FAIL rst_hwdata: got %h exp 0", HWDATA); end
    checks++; if (HBURST !== 3'b000 || HPROT !== 4'b0011) begin
      fails++; $display("FAIL rst_const: got %b/%b exp 000/0011", HBURST, HPROT); end
    checks++; if (rsp_valid !== 1'b0 || rsp_write !== 1'b0 || rsp_error !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++; $display("FAIL rst_rsp: got %b/%b/%b/%h exp 0/0/0/0", rsp_valid, rsp_write, rsp_error, rsp_rdata); end
    checks++; if (cmd_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b exp 0", cmd_ready); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick(2);
    checks++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b exp 1", cmd_ready); end
  endtask

  task automatic test_write_read;
    int a0, a1, b;
    b = rsp_cyc_q.size();
    issue(1'b1, 8'h10, 3'b010, 32'hA5A5_0001, a0);
    checks++; if (HTRANS !== 2'b10 || HSEL !== 1'b1 || HADDR !== 8'h10) begin
      fails++; $display("FAIL wr_aphase: got %b/%b/%h exp 10/1/10", HTRANS, HSEL, HADDR); end
    issue(1'b0, 8'h10, 3'b010, 32'h0, a1);
    cmd_valid = 1'b0;
    checks++; if (HTRANS !== 2'b10 || HWRITE !== 1'b0 || a1 != a0 + 1) begin
      fails++; $display("FAIL rd_aphase: got %b/%b acc %0d exp 10/0 acc %0d", HTRANS, HWRITE, a1, a0 + 1); end
    checks++; if (HWDATA !== 32'hA5A5_0001) begin fails++; $display("FAIL wr_hwdata: got %h exp a5a50001", HWDATA); end
    wait_rsp(b + 2);
    tick(4);
    checks++; if (rsp_cyc_q.size() != b + 2) begin fails++; $display("FAIL wr_rd_count: got %0d exp %0d", rsp_cyc_q.size() - b, 2); end
    checks++; if (rsp_cyc_q[b] != a0 + 3 || rsp_w_q[b] !== 1'b1 || rsp_e_q[b] !== 1'b0) begin
      fails++; $display("FAIL wr_rsp: got cyc %0d w %b e %b exp cyc %0d w 1 e 0", rsp_cyc_q[b], rsp_w_q[b], rsp_e_q[b], a0 + 3); end
    checks++; if (rsp_cyc_q[b+1] != a1 + 3 || rsp_w_q[b+1] !== 1'b0 || rsp_e_q[b+1] !== 1'b0) begin
      fails++; $display("FAIL rd_rsp: got cyc %0d w %b e %b exp cyc %0d w 0 e 0", rsp_cyc_q[b+1], rsp_w_q[b+1], rsp_e_q[b+1], a1 + 3); end
    checks++; if (rsp_d_q[b+1] !== 32'hA5A5_0001) begin fails++; $display("FAIL rd_data: got %h exp a5a50001", rsp_d_q[b+1]); end
  endtask

  task automatic test_back_to_back;
    int acc[4];
    int b;
    b = rsp_cyc_q.size();
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 8'(4 * k), 3'b010, 32'h1111_0000 + k, acc[k]);
      checks++; if (acc[k] != acc[0] + k) begin fails++; $display("FAIL b2b_ready: cmd %0d acc %0d exp %0d", k, acc[k], acc[0] + k); end
    end
    cmd_valid = 1'b0;
    wait_rsp(b + 4);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rsp_cyc_q[b+k] != acc[0] + 3 + k || rsp_w_q[b+k] !== 1'b1 || rsp_e_q[b+k] !== 1'b0) begin
        fails++; $display("FAIL b2b_rsp%0d: got cyc %0d w %b e %b exp cyc %0d w 1 e 0", k, rsp_cyc_q[b+k], rsp_w_q[b+k], rsp_e_q[b+k], acc[0] + 3 + k); end
    end
    tick(3);
  endtask

  task automatic test_wait_states;
    int a0, a1, b, aw;
    issue(1'b1, 8'h20, 3'b010, 32'hCAFE_0020, aw);
    cmd_valid = 1'b0;
    tick(5);
    b = rsp_cyc_q.size();
    wait_en = 1'b1; wait_addr = 8'h20; wait_n = 2;
    issue(1'b0, 8'h20, 3'b010, 32'h0, a0);
    issue(1'b0, 8'h10, 3'b010, 32'h0, a1);
    cmd_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (HREADY !== 1'b0 || HTRANS !== 2'b10 || HADDR !== 8'h10) begin
        fails++; $display("FAIL wait_hold%0d: got hready %b htrans %b haddr %h exp 0/10/10", k, HREADY, HTRANS, HADDR); end
      tick(1);
    end
    checks++; if (HREADY !== 1'b1) begin fails++; $display("FAIL wait_end: got hready %b exp 1", HREADY); end
    wait_rsp(b + 2);
    wait_en = 1'b0;
    checks++; if (rsp_cyc_q[b] != a0 + 5 || rsp_d_q[b] !== 32'hCAFE_0020) begin
      fails++; $display("FAIL wait_rsp0: got cyc %0d data %h exp cyc %0d data cafe0020", rsp_cyc_q[b], rsp_d_q[b], a0 + 5); end
    checks++; if (rsp_cyc_q[b+1] != a0 + 6 || rsp_d_q[b+1] !== 32'hA5A5_0001) begin
      fails++; $display("FAIL wait_rsp1: got cyc %0d data %h exp cyc %0d data a5a50001", rsp_cyc_q[b+1], rsp_d_q[b+1], a0 + 6); end
    tick(3);
  endtask

  task automatic test_error_replay;
    int aw, ar, b;
    b = rsp_cyc_q.size();
    err_en = 1'b1; err_addr = 8'hFC;
    issue(1'b1, 8'hFC, 3'b010, 32'hDEAD_00FC, aw);
    issue(1'b0, 8'h04, 3'b010, 32'h0, ar);
    cmd_write = 1'b0; cmd_addr = 8'h08; cmd_size = 3'b010;
    checks++; if (cmd_ready !== 1'b0 || HTRANS !== 2'b10 || HADDR !== 8'h04) begin
      fails++; $display("FAIL err1_cycle: got ready %b htrans %b haddr %h exp 0/10/04", cmd_ready, HTRANS, HADDR); end
    tick(1);
    checks++; if (cmd_ready !== 1'b0 || HTRANS !== 2'b00 || HSEL !== 1'b0) begin
      fails++; $display("FAIL err2_cycle: got ready %b htrans %b hsel %b exp 0/00/0", cmd_ready, HTRANS, HSEL); end
    tick(1);
    checks++; if (cmd_ready !== 1'b1 || HTRANS !== 2'b10 || HADDR !== 8'h04) begin
      fails++; $display("FAIL replay_issue: got ready %b htrans %b haddr %h exp 1/10/04", cmd_ready, HTRANS, HADDR); end
    tick(1);
    cmd_valid = 1'b0;
    checks++; if (HADDR !== 8'h08 || HTRANS !== 2'b10) begin
      fails++; $display("FAIL after_replay: got haddr %h htrans %b exp 08/10", HADDR, HTRANS); end
    wait_rsp(b + 3);
    err_en = 1'b0;
    tick(4);
    checks++; if (rsp_cyc_q.size() != b + 3) begin fails++; $display("FAIL err_count: got %0d exp 3", rsp_cyc_q.size() - b); end
    checks++; if (rsp_cyc_q[b] != aw + 4 || rsp_w_q[b] !== 1'b1 || rsp_e_q[b] !== 1'b1 || rsp_d_q[b] !== 32'h0) begin
      fails++; $display("FAIL err_rsp: got cyc %0d w %b e %b d %h exp cyc %0d w 1 e 1 d 0", rsp_cyc_q[b], rsp_w_q[b], rsp_e_q[b], rsp_d_q[b], aw + 4); end
    checks++; if (rsp_cyc_q[b+1] != aw + 6 || rsp_w_q[b+1] !== 1'b0 || rsp_e_q[b+1] !== 1'b0 || rsp_d_q[b+1] !== 32'h1111_0001) begin
      fails++; $display("FAIL replay_rsp: got cyc %0d w %b e %b d %h exp cyc %0d w 0 e 0 d 11110001", rsp_cyc_q[b+1], rsp_w_q[b+1], rsp_e_q[b+1], rsp_d_q[b+1], aw + 6); end
    checks++; if (rsp_cyc_q[b+2] != aw + 7 || rsp_e_q[b+2] !== 1'b0 || rsp_d_q[b+2] !== 32'h1111_0002) begin
      fails++; $display("FAIL newer_rsp: got cyc %0d e %b d %h exp cyc %0d e 0 d 11110002", rsp_cyc_q[b+2], rsp_e_q[b+2], rsp_d_q[b+2], aw + 7); end
    if (ar < 0) tick(1);
  endtask

  task automatic test_size_align;
    int a0, a1, b;
    b = rsp_cyc_q.size();
    issue(1'b1, 8'h13, 3'b011, 32'h1234_5678, a0);
    checks++; if (HSIZE !== 3'b010 || HADDR !== 8'h10 || HWRITE !== 1'b1) begin
      fails++; $display("FAIL size_sat: got hsize %b haddr %h hwrite %b exp 010/10/1", HSIZE, HADDR, HWRITE); end
    issue(1'b1, 8'h13, 3'b001, 32'h00AB_0000, a1);
    cmd_valid = 1'b0;
    checks++; if (HSIZE !== 3'b001 || HADDR !== 8'h12 || HWDATA !== 32'h1234_5678) begin
      fails++; $display("FAIL size_half: got hsize %b haddr %h hwdata %h exp 001/12/12345678", HSIZE, HADDR, HWDATA); end
    wait_rsp(b + 2);
    tick(3);
  endtask

  task automatic test_reset_mid;
    int a0, b;
    b = rsp_cyc_q.size();
    issue(1'b0, 8'h10, 3'b010, 32'hDEAD_BEEF, a0);
    cmd_valid = 1'b0;
    wait_rsp(b + 1);
    checks++; if (rsp_d_q[b] !== 32'h00AB_0000) begin fails++; $display("FAIL pre_rst_read: got %h exp 00ab0000", rsp_d_q[b]); end
    tick(2);
    wait_en = 1'b1; wait_addr = 8'h08; wait_n = 5;
    issue(1'b0, 8'h08, 3'b010, 32'hDEAD_BEEF, a0);
    cmd_valid = 1'b0;
    tick(1);
    b = rsp_cyc_q.size();
    checks++; if (HREADY !== 1'b0 || HWDATA !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL mid_wait: got hready %b hwdata %h exp 0/deadbeef", HREADY, HWDATA); end
    #2;
    HRESETn = 1'b0;
    #1;
    checks++; if (HTRANS !== 2'b00 || HSEL !== 1'b0 || HADDR !== 8'h00 || HSIZE !== 3'b000 || HWRITE !== 1'b0) begin
      fails++; $display("FAIL mid_rst_a: got %b/%b/%h/%b/%b exp 00/0/00/000/0", HTRANS, HSEL, HADDR, HSIZE, HWRITE); end
    checks++; if (HWDATA !== 32'h0 || HPROT !== 4'b0011 || HBURST !== 3'b000) begin
      fails++; $display("FAIL mid_rst_d: got %h/%b/%b exp 0/0011/000", HWDATA, HPROT, HBURST); end
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || cmd_ready !== 1'b0) begin
      fails++; $display("FAIL mid_rst_rsp: got %b/%h/%b exp 0/0/0", rsp_valid, rsp_rdata, cmd_ready); end
    wait_en = 1'b0;
    tick(2);
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick(10);
    checks++; if (rsp_cyc_q.size() != b || HTRANS !== 2'b00) begin
      fails++; $display("FAIL post_rst: got %0d rsp htrans %b exp 0 rsp 00", rsp_cyc_q.size() - b, HTRANS); end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_back_to_back;
    test_wait_states;
    test_error_replay;
    test_size_align;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
